// File: rtl/enc_pkg.sv
// Shared types and width constants for the 8-to-3 streaming priority encoder.
package enc_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/enc8_3_if.sv
// Input vector handshake plus indexed output stream of the enc8_3 encoder.
interface enc8_3_if;
  import enc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_y;
  logic             out_last;
  logic             out_none;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_y, out_last, out_none
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_y, out_last, out_none
  );

endinterface

// File: rtl/pri_enc8.sv
// Combinational priority encoder over an 8-bit mask, direction selectable.
module pri_enc8
  import enc_pkg::*;
(
  input  logic [IN_W-1:0]  mask,
  input  logic             lsb_first,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             single
);

  // The last assignment in scan order wins, so scan away from the priority end.
  always_comb begin
    idx = '0;
    if (lsb_first) begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (mask[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (mask[i]) idx = IDX_W'(i);
      end
    end
  end

  assign found  = |mask;
  assign single = found && ((mask & (mask - IN_W'(1))) == '0);

endmodule

// File: rtl/enc8_3.sv
// Streaming encoder: accepts an 8-bit request vector and emits the index of
// each set bit, one per handshake, in LSB-first or MSB-first order.
module enc8_3
  import enc_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  enc8_3_if.slave  bus
);

  state_t           state, state_nxt;
  logic [IN_W-1:0]  pending, pending_nxt;
  logic             none_q, none_nxt;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic             single;
  logic             emit_last;

  pri_enc8 u_pri (
    .mask      (pending),
    .lsb_first (LSB_FIRST != 0),
    .idx       (idx),
    .found     (found),
    .single    (single)
  );

  // An empty pending mask in EMIT is the all-zero vector's single output.
  assign emit_last = !found || single;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      none_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      none_q  <= none_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    none_nxt    = none_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          pending_nxt = bus.in_x;
          none_nxt    = (bus.in_x == '0);
          state_nxt   = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pending_nxt = pending & ~(IN_W'(1) << idx);
          if (emit_last) begin
            state_nxt = IDLE;
            none_nxt  = 1'b0;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == EMIT);
    bus.out_y     = '0;
    bus.out_last  = 1'b0;
    bus.out_none  = 1'b0;
    if (state == EMIT) begin
      bus.out_y    = idx;
      bus.out_last = emit_last;
      bus.out_none = none_q;
    end
  end

endmodule

// File: tb/tb_enc8_3.sv
// Directed bench driving an LSB-first and an MSB-first enc8_3 side by side.
module tb_enc8_3;

  logic clk;
  logic rst_n;
  int   check_count;
  int   error_count;

  enc8_3_if if_lsb ();
  enc8_3_if if_msb ();

  enc8_3 #(.LSB_FIRST(1)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(if_lsb));
  enc8_3 #(.LSB_FIRST(0)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(if_msb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] ST_IDLE = 7'b100_0000;

  // Status word: {in_ready, out_valid, out_y, out_last, out_none}
  function automatic logic [6:0] emit(input logic [2:0] y, input logic last, input logic none);
    return {1'b0, 1'b1, y, last, none};
  endfunction

  function automatic logic [6:0] status_lsb();
    return {if_lsb.in_ready, if_lsb.out_valid, if_lsb.out_y, if_lsb.out_last, if_lsb.out_none};
  endfunction

  function automatic logic [6:0] status_msb();
    return {if_msb.in_ready, if_msb.out_valid, if_msb.out_y, if_msb.out_last, if_msb.out_none};
  endfunction

  task automatic checkOutput(input string tag, input logic [6:0] actual, input logic [6:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
    end
  endtask

  task automatic check_both(input string tag, input logic [6:0] exp_lsb, input logic [6:0] exp_msb);
    checkOutput({tag, "/lsb"}, status_lsb(), exp_lsb);
    checkOutput({tag, "/msb"}, status_msb(), exp_msb);
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] x, input logic ready);
    if_lsb.in_valid = valid; if_lsb.in_x = x; if_lsb.out_ready = ready;
    if_msb.in_valid = valid; if_msb.in_x = x; if_msb.out_ready = ready;
  endtask

  // Advance one clock; returns on the falling edge so outputs are settled.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h20, 1'b1);
    @(negedge clk);
    check_both("reset", ST_IDLE, ST_IDLE);
    cycle();
    check_both("reset_hold_valid", ST_IDLE, ST_IDLE);
    applyStimulus(1'b0, 8'h00, 1'b1);
    rst_n = 1'b1;
    cycle();
    check_both("post_reset_idle", ST_IDLE, ST_IDLE);

    // One-hot
    applyStimulus(1'b1, 8'b0010_0000, 1'b1);
    cycle();
    check_both("onehot", emit(3'd5, 1'b1, 1'b0), emit(3'd5, 1'b1, 1'b0));
    applyStimulus(1'b0, 8'h00, 1'b1);
    cycle();
    check_both("onehot_idle", ST_IDLE, ST_IDLE);

    // Multi-hot, with a competing vector offered while busy
    applyStimulus(1'b1, 8'b1001_0010, 1'b1);
    cycle();
    applyStimulus(1'b1, 8'h01, 1'b1);
    check_both("multi_0", emit(3'd1, 1'b0, 1'b0), emit(3'd7, 1'b0, 1'b0));
    cycle();
    check_both("multi_1", emit(3'd4, 1'b0, 1'b0), emit(3'd4, 1'b0, 1'b0));
    cycle();
    check_both("multi_2", emit(3'd7, 1'b1, 1'b0), emit(3'd1, 1'b1, 1'b0));
    applyStimulus(1'b0, 8'h00, 1'b1);
    cycle();
    check_both("multi_idle", ST_IDLE, ST_IDLE);

    // Zero vector, then a held request shows the mandatory idle cycle
    applyStimulus(1'b1, 8'h00, 1'b1);
    cycle();
    applyStimulus(1'b1, 8'h08, 1'b1);
    check_both("zero", emit(3'd0, 1'b1, 1'b1), emit(3'd0, 1'b1, 1'b1));
    cycle();
    check_both("turnaround_idle", ST_IDLE, ST_IDLE);
    cycle();
    check_both("after_zero", emit(3'd3, 1'b1, 1'b0), emit(3'd3, 1'b1, 1'b0));
    applyStimulus(1'b0, 8'h00, 1'b1);
    cycle();
    check_both("after_zero_idle", ST_IDLE, ST_IDLE);

    // Full vector with backpressure pattern 1,0,0,1,...
    applyStimulus(1'b1, 8'hFF, 1'b1);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] li;
      logic [2:0] mi;
      li = 3'(i);
      mi = 3'(7 - i);
      if (i % 2 == 1) begin
        applyStimulus(1'b0, 8'h00, 1'b0);
        check_both($sformatf("bp_stall_a%0d", i), emit(li, i == 7, 1'b0), emit(mi, i == 7, 1'b0));
        cycle();
        check_both($sformatf("bp_stall_b%0d", i), emit(li, i == 7, 1'b0), emit(mi, i == 7, 1'b0));
        cycle();
        applyStimulus(1'b0, 8'h00, 1'b1);
      end
      check_both($sformatf("bp_take%0d", i), emit(li, i == 7, 1'b0), emit(mi, i == 7, 1'b0));
      cycle();
    end
    check_both("bp_idle", ST_IDLE, ST_IDLE);

    // Reset mid-stream after three outputs
    applyStimulus(1'b1, 8'hFF, 1'b1);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_both($sformatf("rst_stream%0d", i), emit(3'(i), 1'b0, 1'b0), emit(3'(7 - i), 1'b0, 1'b0));
      cycle();
    end
    rst_n = 1'b0;
    #1;
    check_both("rst_async", ST_IDLE, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_both($sformatf("rst_after%0d", i), ST_IDLE, ST_IDLE);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/enc8_3.md
ENC8_3 -- requirements
Module: enc8_3

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1: 1 = lowest set bit is emitted first; 0 = highest set bit first.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in_valid  input  1  in_x holds a vector to encode.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a vector this cycle.
REQ-006 The block SHALL have port in_x  input  8  one-hot or multi-hot request vector.
REQ-007 The block SHALL have port out_valid  output  1  out_y/out_last/out_none are valid.
REQ-008 The block SHALL have port out_ready  input  1  consumer accepts the current output.
REQ-009 The block SHALL have port out_y  output  3  bit index of the current set bit.
REQ-010 The block SHALL have port out_last  output  1  current index is the final one for the vector.
REQ-011 The block SHALL have port out_none  output  1  accepted vector was all-zero.

Function
REQ-012 The block SHALL use two states: IDLE and EMIT.
REQ-013 In IDLE, in_ready SHALL be 1, out_valid 0, and out_y/out_last/out_none 0.
REQ-014 In IDLE, in_valid=1 SHALL latch in_x into an 8-bit pending mask and move to EMIT on the same edge.
REQ-015 The first output SHALL be valid in the cycle after acceptance (latency 1); all outputs SHALL come from registers.
REQ-016 In EMIT, in_ready SHALL be 0, out_valid 1, and out_y the index of the priority set bit of pending, with priority per LSB_FIRST.
REQ-017 out_last SHALL be 1 exactly when pending holds one set bit, or none.
REQ-018 On out_valid and out_ready, the emitted bit SHALL be cleared from pending; if out_last=1 the state SHALL return to IDLE, otherwise out_y SHALL advance to the next index on that edge.
REQ-019 With out_ready held at 1, one index SHALL be emitted per cycle, so a vector with k set bits occupies EMIT for k cycles.
REQ-020 While out_ready=0, out_y/out_last/out_none SHALL stay stable (no change while valid and not accepted).
REQ-021 An all-zero in_x SHALL produce exactly one output: out_y=0, out_none=1, out_last=1.
REQ-022 out_none SHALL be 0 for any non-zero vector.
REQ-023 in_x=8'hFF SHALL produce 8 outputs in order 0..7 (LSB_FIRST=1) or 7..0 (LSB_FIRST=0), with out_last on the eighth.
REQ-024 After the final handshake the block SHALL spend one cycle in IDLE before accepting again (no same-cycle turnaround), giving a maximum throughput of one vector per (k+1) cycles.
REQ-025 in_x SHALL be ignored when in_ready=0.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, pending=0, in_ready=1, out_valid=0, and out_y/out_last/out_none=0.
REQ-027 Reset asserted during EMIT SHALL drop the remaining indices; no partial output SHALL appear after release.
REQ-028 The first accept SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-029 State encoding (IDLE/EMIT) and the width constants (IN_W=8, IDX_W=3) SHALL live in the shared package enc_pkg.
REQ-030 A combinational sub-module pri_enc8 SHALL be used: inputs an 8-bit mask and the direction; outputs a 3-bit index, a found flag and a single-bit flag; instantiated once on pending.
REQ-031 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-032 Scenario: reset mid-stream -- in_x=8'hFF accepted, rst_n pulsed low after 3 outputs -> outputs zero immediately, in_ready=1, nothing further emitted after release.
REQ-033 Scenario: one-hot -- in_x=8'b0010_0000, out_ready=1 -> one cycle later out_y=5, out_last=1, out_none=0; in_ready=1 the following cycle.
REQ-034 Scenario: multi-hot, LSB_FIRST=1 -- in_x=8'b1001_0010 -> out_y sequence 1,4,7 on consecutive cycles, out_last only with 7.
REQ-035 Scenario: LSB_FIRST=0, in_x=8'b1001_0010 -> out_y sequence 7,4,1.
REQ-036 Scenario: zero vector -- in_x=0 -> single output with out_y=0, out_none=1, out_last=1.
REQ-037 Scenario: backpressure -- in_x=8'hFF, out_ready toggled 1,0,0,1,... -> out_y holds during stalls, all 8 indices appear once in order, in_ready stays 0 until the last handshake completes.
